io_output_bank: RTL and testbench
=================================

// Module: io_output_bank
// PURPOSE
//  Parametrised memory-mapped output-port bank on the CPU IO write bus. Provides NUM_PORTS
//  DATA_W-bit output registers with byte enables and write/set/clear/toggle access modes.
//  Each port also has an optional auto-clear pulse mode driven by a per-port down-counter.
//  A registered readback path returns any port or the control register to the CPU.
// PARAMETERS
//  NUM_PORTS   4      number of output ports, 1..16
//  DATA_W      32     port width in bits; multiple of 8, <= 32
//  BASE_ADDR   8'h80  byte address of port 0; 4-byte aligned; BASE_ADDR+4*NUM_PORTS+3 <= 8'hFF
//  PULSE_LEN   16     pulse-mode hold time in io_clk cycles, >= 1
//  CNT_W       16     pulse counter width; 2**CNT_W > PULSE_LEN
// PORTS
//  io_clk           in   1                 clock; all state updates on rising edge
//  resetn           in   1                 asynchronous, active-low reset
//  addr             in   32                byte address; [7:0] = window offset, [9:8] = mode, [31:10] ignored
//  datain           in   32                write data; only [DATA_W-1:0] used
//  byte_en          in   DATA_W/8          per-byte write enable, applied to all modes
//  write_io_enable  in   1                 write strobe, one access per asserted cycle
//  read_io_enable   in   1                 read strobe
//  dataout          out  32                readback data, zero-extended
//  dataout_valid    out  1                 high exactly one cycle after an accepted read
//  out_port         out  NUM_PORTS*DATA_W  flattened ports; port i = [i*DATA_W +: DATA_W]
//  pulse_active     out  NUM_PORTS         bit i high while port i pulse counter is nonzero
// BEHAVIOUR
//  Reset: all ports 0, CTRL 0, counters 0, dataout 0, dataout_valid 0, pulse_active 0.
//   Reset asserted mid-pulse clears the port and counter immediately, no completion.
//  Address map on addr[7:0]:
//   - Port i is at BASE_ADDR + 4*i.
//   - CTRL is at BASE_ADDR + 4*NUM_PORTS; bits [NUM_PORTS-1:0] = pulse_en; other bits read 0.
//   - addr[1:0] is ignored. Unmapped offsets: writes ignored, reads return 0 with valid.
//  Write modes (addr[9:8]), applied per enabled byte lane b; disabled lanes keep old value:
//   - 00 WRITE: port[b] = d[b]
//   - 01 SET:   port[b] |= d[b]
//   - 10 CLR:   port[b] &= ~d[b]
//   - 11 TGL:   port[b] ^= d[b]
//  CTRL always uses WRITE semantics regardless of mode; byte_en[0] gates bits [7:0], and so on.
//  Write latency: out_port reflects the write on the cycle after the strobe edge.
//  Pulse mode (pulse_en[i]=1):
//   - Any accepted write to port i loads cnt[i]=PULSE_LEN.
//   - Each later cycle with cnt[i]!=0 decrements cnt[i].
//   - When cnt[i] goes 1->0, port i is cleared to 0 in the same edge.
//   - So the written value is visible for exactly PULSE_LEN cycles.
//   - A write to port i while cnt[i]!=0 reloads the counter and applies the new value
//     (retrigger); write beats expiry in the same cycle.
//   - Clearing pulse_en[i] forces cnt[i]=0 next edge and holds the port value (no auto-clear).
//   - Setting pulse_en[i] does not start a counter until the next port write.
//   - pulse_active[i] = (cnt[i]!=0), registered.
//   - With pulse_en[i]=0 the port holds its value indefinitely; the counter stays 0.
//  Readback:
//   - read_io_enable sampled at edge N; dataout/dataout_valid update at edge N.
//   - dataout holds the pre-write value if a same-cycle write targets the same register.
//   - dataout holds its value when idle; dataout_valid drops the next cycle.
//  Simultaneous read and write in one cycle are both accepted.
//  Ports are independent; different ports may expire in the same cycle.
// TESTING
//  1 Reset then WRITE 0x80=0xDEADBEEF, be=1111 -> port0=0xDEADBEEF next cycle; ports1-3=0; read 0x80 -> dataout=0xDEADBEEF, valid 1 cycle.
//  2 port1=0x000000F0; SET 0x184 d=0x0F; CLR 0x284 d=0x30; TGL 0x384 d=0xFF -> port1 0xFF, 0xCF, 0x30.
//  3 WRITE 0x88=0x11223344 be=0101 over port2=0xAAAAAAAA -> port2=0xAA22AA44.
//  4 CTRL(0x90)=0x8; write 0x8C=0x5 -> port3=5, pulse_active[3]=1 for 16 cycles, then port3=0, pulse_active[3]=0.
//  5 Retrigger: write 0x8C at count 5 remaining -> expiry delayed, 16 more cycles; write on expiry cycle -> new value held 16 cycles.
//  6 Write to 0xA0/0x40 -> no port change, read returns 0; assert resetn mid-pulse -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/io_output_bank.sv
// io_output_bank: memory-mapped bank of output ports with byte-enabled
// write/set/clear/toggle access, per-port auto-clear pulse mode and a
// registered readback path.
//   io_clk, resetn (async, active-low)
//   addr[7:0] window offset, addr[9:8] access mode, datain, byte_en
//   write_io_enable / read_io_enable strobes
//   dataout, dataout_valid: readback, one cycle after the read strobe
//   out_port: flattened ports, port i at [i*DATA_W +: DATA_W]
//   pulse_active: per-port pulse counter nonzero
module io_output_bank #(
    parameter int          NUM_PORTS = 4,
    parameter int          DATA_W    = 32,
    parameter logic [7:0]  BASE_ADDR = 8'h80,
    parameter int          PULSE_LEN = 16,
    parameter int          CNT_W     = 16
) (
    input  logic                          io_clk,
    input  logic                          resetn,
    input  logic [31:0]                   addr,
    input  logic [31:0]                   datain,
    input  logic [DATA_W/8-1:0]           byte_en,
    input  logic                          write_io_enable,
    input  logic                          read_io_enable,
    output logic [31:0]                   dataout,
    output logic                          dataout_valid,
    output logic [NUM_PORTS*DATA_W-1:0]   out_port,
    output logic [NUM_PORTS-1:0]          pulse_active
);
    logic [NUM_PORTS*DATA_W-1:0] port_q, port_d;
    logic [NUM_PORTS-1:0]        pulse_en_q, pulse_en_d;
    logic [CNT_W-1:0]            cnt_q [NUM_PORTS];
    logic [CNT_W-1:0]            cnt_d [NUM_PORTS];
    logic [31:0]                 dataout_q, dataout_d, rd_data;
    logic                        dataout_valid_q;
    logic [DATA_W-1:0]           wd, mask, old, modv;
    logic [1:0]                  mode, be_pad;
    logic [5:0]                  widx;
    logic                        in_win, hit, ctrl_hit;
    logic                        unused_ok;

    // Address decode works on 32-bit words; addr[1:0] never matters.
    assign mode      = addr[9:8];
    assign widx      = addr[7:2] - BASE_ADDR[7:2];
    assign in_win    = addr[7:2] >= BASE_ADDR[7:2];
    assign ctrl_hit  = in_win && widx == 6'(NUM_PORTS);
    assign wd        = datain[DATA_W-1:0];
    // CTRL may be wider than the byte enables when DATA_W is 8; missing lanes read as disabled.
    assign be_pad    = 2'(byte_en);
    assign unused_ok = ^{addr[31:10], addr[1:0], datain};

    always_comb begin
        port_d     = port_q;
        pulse_en_d = pulse_en_q;
        cnt_d      = cnt_q;
        rd_data    = '0;
        mask       = '0;
        old        = '0;
        modv       = '0;
        hit        = 1'b0;
        pulse_active = '0;
        for (int b = 0; b < DATA_W/8; b++) mask[b*8 +: 8] = {8{byte_en[b]}};
        if (ctrl_hit) rd_data = 32'(pulse_en_q);
        if (ctrl_hit && write_io_enable)
            for (int k = 0; k < NUM_PORTS; k++) pulse_en_d[k] = be_pad[k/8] ? datain[k] : pulse_en_q[k];
        for (int i = 0; i < NUM_PORTS; i++) begin
            old  = port_q[i*DATA_W +: DATA_W];
            hit  = in_win && widx == 6'(i);
            modv = mode == 2'd0 ? wd : mode == 2'd1 ? old | wd : mode == 2'd2 ? old & ~wd : old ^ wd;
            if (hit) rd_data = 32'(old);
            // Disabling pulse mode kills the counter at once and freezes the port value.
            if (!pulse_en_d[i]) cnt_d[i] = '0;
            else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
                if (cnt_q[i] == CNT_W'(1)) port_d[i*DATA_W +: DATA_W] = '0;
            end
            // A write overrides a same-cycle expiry and retriggers the counter.
            if (hit && write_io_enable) begin
                port_d[i*DATA_W +: DATA_W] = (modv & mask) | (old & ~mask);
                if (pulse_en_d[i]) cnt_d[i] = CNT_W'(PULSE_LEN);
            end
            pulse_active[i] = cnt_q[i] != '0;
        end
        dataout_d = read_io_enable ? rd_data : dataout_q;
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            port_q          <= '0;
            pulse_en_q      <= '0;
            cnt_q           <= '{default: '0};
            dataout_q       <= '0;
            dataout_valid_q <= 1'b0;
        end else begin
            port_q          <= port_d;
            pulse_en_q      <= pulse_en_d;
            cnt_q           <= cnt_d;
            dataout_q       <= dataout_d;
            dataout_valid_q <= read_io_enable;
        end
    end

    assign out_port      = port_q;
    assign dataout       = dataout_q;
    assign dataout_valid = dataout_valid_q;
endmodule

// File: tb/tb_io_output_bank.sv
// tb_io_output_bank: self-checking bench for io_output_bank with a readback scoreboard.
module tb_io_output_bank;
    logic         io_clk = 1'b0;
    logic         resetn = 1'b0;
    logic [31:0]  addr = '0, datain = '0;
    logic [3:0]   byte_en = '0;
    logic         write_io_enable = 1'b0, read_io_enable = 1'b0;
    logic [31:0]  dataout;
    logic         dataout_valid;
    logic [127:0] out_port;
    logic [3:0]   pulse_active;
    int           vec = 0, errs = 0;
    logic [31:0]  sb [$];
    logic [31:0]  exp_v;

    io_output_bank dut (
        .io_clk(io_clk), .resetn(resetn), .addr(addr), .datain(datain), .byte_en(byte_en),
        .write_io_enable(write_io_enable), .read_io_enable(read_io_enable),
        .dataout(dataout), .dataout_valid(dataout_valid),
        .out_port(out_port), .pulse_active(pulse_active)
    );

    always #5 io_clk = ~io_clk;

    function automatic logic [31:0] port(input int i);
        return out_port[i*32 +: 32];
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; datain = d; byte_en = be; write_io_enable = 1'b1;
        @(negedge io_clk);
        write_io_enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        addr = a; read_io_enable = 1'b1; sb.push_back(e);
        @(negedge io_clk);
        read_io_enable = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge io_clk);
    endtask

    task automatic test_reset;
        vec++; if (out_port !== '0 || pulse_active !== '0) begin errs++; $display("FAIL reset_ports got %h/%h exp 0", out_port, pulse_active); end
        vec++; if (dataout !== '0 || dataout_valid !== 1'b0) begin errs++; $display("FAIL reset_read got %h/%b exp 0/0", dataout, dataout_valid); end
    endtask

    task automatic test_write_read;
        wr(32'h80, 32'hDEADBEEF, 4'hF);
        vec++; if (out_port !== {96'h0, 32'hDEADBEEF}) begin errs++; $display("FAIL write_port0 got %h exp %h", out_port, {96'h0, 32'hDEADBEEF}); end
        rd(32'h80, 32'hDEADBEEF);
        exp_v = sb.pop_front();
        vec++; if (dataout !== exp_v || dataout_valid !== 1'b1) begin errs++; $display("FAIL read_port0 got %h/%b exp %h/1", dataout, dataout_valid, exp_v); end
        wait_cyc(1);
        vec++; if (dataout !== 32'hDEADBEEF || dataout_valid !== 1'b0) begin errs++; $display("FAIL read_hold got %h/%b exp deadbeef/0", dataout, dataout_valid); end
    endtask

    task automatic test_modes;
        wr(32'h084, 32'h000000F0, 4'hF);
        wr(32'h184, 32'h0F, 4'hF);
        vec++; if (port(1) !== 32'hFF) begin errs++; $display("FAIL mode_set got %h exp ff", port(1)); end
        wr(32'h284, 32'h30, 4'hF);
        vec++; if (port(1) !== 32'hCF) begin errs++; $display("FAIL mode_clr got %h exp cf", port(1)); end
        wr(32'h384, 32'hFF, 4'hF);
        vec++; if (port(1) !== 32'h30) begin errs++; $display("FAIL mode_tgl got %h exp 30", port(1)); end
    endtask

    task automatic test_byte_en;
        wr(32'h88, 32'hAAAAAAAA, 4'hF);
        wr(32'h8A, 32'h11223344, 4'b0101);
        vec++; if (port(2) !== 32'hAA22AA44) begin errs++; $display("FAIL byte_en got %h exp aa22aa44", port(2)); end
        rd(32'h88, 32'hAA22AA44);
        exp_v = sb.pop_front();
        vec++; if (dataout !== exp_v || dataout_valid !== 1'b1) begin errs++; $display("FAIL read_port2 got %h exp %h", dataout, exp_v); end
    endtask

    task automatic test_rw_same;
        addr = 32'h80; datain = 32'h12345678; byte_en = 4'hF;
        write_io_enable = 1'b1; read_io_enable = 1'b1; sb.push_back(32'hDEADBEEF);
        @(negedge io_clk);
        write_io_enable = 1'b0; read_io_enable = 1'b0;
        exp_v = sb.pop_front();
        vec++; if (dataout !== exp_v || dataout_valid !== 1'b1) begin errs++; $display("FAIL rw_same_read got %h exp %h", dataout, exp_v); end
        vec++; if (port(0) !== 32'h12345678) begin errs++; $display("FAIL rw_same_write got %h exp 12345678", port(0)); end
    endtask

    task automatic test_pulse;
        wr(32'h90, 32'h8, 4'hF);
        rd(32'h90, 32'h8);
        exp_v = sb.pop_front();
        vec++; if (dataout !== exp_v) begin errs++; $display("FAIL ctrl_read got %h exp %h", dataout, exp_v); end
        wr(32'h8C, 32'h5, 4'hF);
        vec++; if (port(3) !== 32'h5 || pulse_active !== 4'b1000) begin errs++; $display("FAIL pulse_start got %h/%b exp 5/1000", port(3), pulse_active); end
        wait_cyc(15);
        vec++; if (port(3) !== 32'h5 || pulse_active !== 4'b1000) begin errs++; $display("FAIL pulse_last got %h/%b exp 5/1000", port(3), pulse_active); end
        wait_cyc(1);
        vec++; if (port(3) !== 32'h0 || pulse_active !== 4'b0000) begin errs++; $display("FAIL pulse_expire got %h/%b exp 0/0000", port(3), pulse_active); end
        vec++; if (port(0) !== 32'h12345678 || port(2) !== 32'hAA22AA44) begin errs++; $display("FAIL pulse_indep got %h %h exp 12345678 aa22aa44", port(0), port(2)); end
    endtask

    task automatic test_retrigger;
        wr(32'h8C, 32'h5, 4'hF);
        wait_cyc(11);
        wr(32'h8C, 32'h7, 4'hF);
        wait_cyc(15);
        vec++; if (port(3) !== 32'h7 || pulse_active[3] !== 1'b1) begin errs++; $display("FAIL retrig_hold got %h/%b exp 7/1", port(3), pulse_active[3]); end
        wait_cyc(1);
        vec++; if (port(3) !== 32'h0 || pulse_active[3] !== 1'b0) begin errs++; $display("FAIL retrig_expire got %h/%b exp 0/0", port(3), pulse_active[3]); end
        wr(32'h8C, 32'h9, 4'hF);
        wait_cyc(15);
        wr(32'h8C, 32'hA, 4'hF);
        vec++; if (port(3) !== 32'hA || pulse_active[3] !== 1'b1) begin errs++; $display("FAIL expiry_write got %h/%b exp a/1", port(3), pulse_active[3]); end
        wait_cyc(15);
        vec++; if (port(3) !== 32'hA || pulse_active[3] !== 1'b1) begin errs++; $display("FAIL expiry_hold got %h/%b exp a/1", port(3), pulse_active[3]); end
        wait_cyc(1);
        vec++; if (port(3) !== 32'h0 || pulse_active[3] !== 1'b0) begin errs++; $display("FAIL expiry_end got %h/%b exp 0/0", port(3), pulse_active[3]); end
    endtask

    task automatic test_pulse_disable;
        wr(32'h8C, 32'h33, 4'hF);
        wait_cyc(3);
        wr(32'h90, 32'h0, 4'hF);
        vec++; if (pulse_active !== 4'b0000) begin errs++; $display("FAIL disable_cnt got %b exp 0000", pulse_active); end
        wait_cyc(20);
        vec++; if (port(3) !== 32'h33) begin errs++; $display("FAIL disable_hold got %h exp 33", port(3)); end
        wr(32'h90, 32'h8, 4'hF);
        vec++; if (pulse_active !== 4'b0000 || port(3) !== 32'h33) begin errs++; $display("FAIL enable_nostart got %b/%h exp 0000/33", pulse_active, port(3)); end
    endtask

    task automatic test_unmapped_reset;
        wr(32'hA0, 32'hFFFFFFFF, 4'hF);
        wr(32'h40, 32'hFFFFFFFF, 4'hF);
        wr(32'h94, 32'hFFFFFFFF, 4'hF);
        vec++; if (out_port !== {32'h33, 32'hAA22AA44, 32'h30, 32'h12345678}) begin errs++; $display("FAIL unmapped_write got %h", out_port); end
        rd(32'hA0, 32'h0);
        exp_v = sb.pop_front();
        vec++; if (dataout !== exp_v || dataout_valid !== 1'b1) begin errs++; $display("FAIL unmapped_read_a0 got %h/%b exp 0/1", dataout, dataout_valid); end
        rd(32'h80, 32'h12345678);
        exp_v = sb.pop_front();
        vec++; if (dataout !== exp_v) begin errs++; $display("FAIL read_port0_b got %h exp %h", dataout, exp_v); end
        rd(32'h40, 32'h0);
        exp_v = sb.pop_front();
        vec++; if (dataout !== exp_v || dataout_valid !== 1'b1) begin errs++; $display("FAIL unmapped_read_40 got %h/%b exp 0/1", dataout, dataout_valid); end
        wr(32'h8C, 32'h44, 4'hF);
        wait_cyc(3);
        addr = 32'h80; read_io_enable = 1'b1;
        #2 resetn = 1'b0;
        #1;
        vec++; if (out_port !== '0 || pulse_active !== '0 || dataout !== '0 || dataout_valid !== 1'b0) begin errs++; $display("FAIL async_reset got %h/%b/%h/%b exp all 0", out_port, pulse_active, dataout, dataout_valid); end
        read_io_enable = 1'b0;
        @(negedge io_clk);
        resetn = 1'b1;
        wait_cyc(2);
        vec++; if (out_port !== '0 || pulse_active !== '0) begin errs++; $display("FAIL post_reset got %h/%b exp 0", out_port, pulse_active); end
    endtask

    initial begin
        wait_cyc(2);
        resetn = 1'b1;
        wait_cyc(1);
        test_reset;
        test_write_read;
        test_modes;
        test_byte_en;
        test_rw_same;
        test_pulse;
        test_retrigger;
        test_pulse_disable;
        test_unmapped_reset;
        vec++; if (sb.size() != 0) begin errs++; $display("FAIL scoreboard_left got %0d exp 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
